// File: rtl/demux3_pkg.sv
// ----------------------------------------------------------------------------
// demux3_pkg : shared select encodings and limits for the 1-to-3 router
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package demux3_pkg;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic sel_is_legal(input logic [1:0] sel);
    return (sel != SEL_BAD);
  endfunction

endpackage : demux3_pkg

`default_nettype wire

// File: rtl/demux3_route.sv
// ----------------------------------------------------------------------------
// demux3_route : registered 1-to-3 valid/ready router with illegal-select drop
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux3_route
  import demux3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_s,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_a_data,
  output logic [WIDTH-1:0] o_b_data,
  output logic [WIDTH-1:0] o_c_data,
  output logic             o_a_valid,
  output logic             o_b_valid,
  output logic             o_c_valid,
  input  logic             i_a_ready,
  input  logic             i_b_ready,
  input  logic             i_c_ready,
  output logic             o_err,
  output logic [7:0]       o_drop_cnt
);

  logic             r_full;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic [7:0]       r_drop_cnt;

  logic w_out_ready_sel;
  logic w_in_ready;
  logic w_accept;
  logic w_legal;
  logic w_drain;

  // Only the destination named by the held select can release the slot.
  always_comb begin
    w_out_ready_sel = 1'b0;
    unique case (r_sel)
      SEL_A:   w_out_ready_sel = i_a_ready;
      SEL_B:   w_out_ready_sel = i_b_ready;
      SEL_C:   w_out_ready_sel = i_c_ready;
      default: w_out_ready_sel = 1'b0;
    endcase
  end

  assign w_in_ready = rst_n && (!r_full || w_out_ready_sel);
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_legal    = sel_is_legal(i_s);
  assign w_drain    = r_full && w_out_ready_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= 1'b0;
      r_sel      <= SEL_A;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_err <= w_accept && !w_legal;

      // A legal accept refills the slot even when it drains this cycle.
      if (w_accept && w_legal) begin
        r_full <= 1'b1;
        r_sel  <= i_s;
        r_data <= i_d;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end

      if (w_accept && !w_legal && (r_drop_cnt != DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_a_data   = r_data;
  assign o_b_data   = r_data;
  assign o_c_data   = r_data;
  assign o_a_valid  = r_full && (r_sel == SEL_A);
  assign o_b_valid  = r_full && (r_sel == SEL_B);
  assign o_c_valid  = r_full && (r_sel == SEL_C);
  assign o_err      = r_err;
  assign o_drop_cnt = r_drop_cnt;

endmodule : demux3_route

`default_nettype wire
